// File: rtl/conv1d_mac_seq.sv
// 1-D convolution MAC sequencer: one window of KERNEL_LEN taps per start.
// Optional RELU_EN macro clamps negative activations to zero.
module conv1d_mac_seq #(
  parameter int KERNEL_LEN = 3,
  parameter int ADDR_W     = 4,
  parameter int ACC_W      = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  in_base,
  input  logic signed [15:0] bias,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  data_addr,
  output logic [3:0]         wgt_addr,
  input  logic signed [7:0]  data_in,
  input  logic signed [7:0]  wgt_in,
  output logic               busy,
  output logic signed [15:0] result,
  output logic               result_valid,
  input  logic               result_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST,
    OUT
  } state_t;

  localparam logic [3:0] TAP_LAST = 4'(KERNEL_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t state;
  state_t nstate;

  logic [ADDR_W-1:0]       base;
  logic [3:0]              tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [15:0]      sat;
  logic signed [15:0]      act;

  assign prod = 16'(data_in) * 16'(wgt_in);
  assign sum  = acc + ACC_W'(prod);

  always_comb begin
    sat = sum[15:0];
    if (sum > SAT_MAX) begin
      sat = 16'sh7fff;
    end else if (sum < SAT_MIN) begin
      sat = 16'sh8000;
    end
  end

`ifdef RELU_EN
  assign act = sat[15] ? 16'sd0 : sat;
`else
  assign act = sat;
`endif

  assign data_addr = base + ADDR_W'(tap);
  assign wgt_addr  = tap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = RUN;
      RUN:  if (tap == TAP_LAST) nstate = LAST;
      LAST: nstate = OUT;
      OUT:  if (result_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == RUN);
    busy  = (state != IDLE);
  end

  // The first RUN edge only launches tap 0; its data lands one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base         <= '0;
      tap          <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base <= in_base;
            acc  <= ACC_W'(bias);
            tap  <= '0;
          end
        end
        RUN: begin
          tap <= tap + 4'd1;
          if (tap != 4'd0) acc <= sum;
        end
        LAST: begin
          result       <= act;
          result_valid <= 1'b1;
        end
        OUT: begin
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_mac_seq.sv
// Scoreboard bench for conv1d_mac_seq with synchronous sample/weight memories.
// Expected activations are queued at launch and popped on each handshake.
module tb_conv1d_mac_seq;

  localparam int K = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         in_base = '0;
  logic signed [15:0] bias = '0;
  logic               rd_en;
  logic [3:0]         data_addr;
  logic [3:0]         wgt_addr;
  logic signed [7:0]  data_in;
  logic signed [7:0]  wgt_in;
  logic               busy;
  logic signed [15:0] result;
  logic               result_valid;
  logic               result_ready = 1'b0;

  logic signed [7:0] mem [16];
  logic signed [7:0] rom [16];

  int npass = 0;
  int ntot  = 0;
  int q[$];

  conv1d_mac_seq #(
    .KERNEL_LEN(K),
    .ADDR_W(4),
    .ACC_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_base(in_base),
    .bias(bias),
    .rd_en(rd_en),
    .data_addr(data_addr),
    .wgt_addr(wgt_addr),
    .data_in(data_in),
    .wgt_in(wgt_in),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      data_in <= mem[data_addr];
      wgt_in  <= rom[wgt_addr];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    if (obs == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model(input logic [3:0] b, input int bs);
    int s = bs;
    for (int i = 0; i < K; i++)
      s += int'(mem[(int'(b) + i) % 16]) * int'(rom[i]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (q.size() == 0) chk("spurious_result", 1, 0);
      else chk("result", int'(result), q.pop_front());
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_valid"}, result_valid, 0);
    chk({pfx, "_result"}, int'(result), 0);
    chk({pfx, "_data_addr"}, data_addr, 0);
    chk({pfx, "_wgt_addr"}, wgt_addr, 0);
  endtask

  task automatic launch(input logic [3:0] b, input int bs, input bit push);
    @(posedge clk); #1;
    in_base = b;
    bias    = 16'(bs);
    start   = 1'b1;
    if (push) q.push_back(model(b, bs));
    @(posedge clk); #1;
    start   = 1'b0;
    in_base = 4'($urandom);
    bias    = 16'($urandom);
  endtask

  task automatic collect(input logic [3:0] b);
    int  k = 0;
    int  cnt = 0;
    bit  done = 0;
    while (!done) begin
      if (rd_en) begin
        chk("data_addr", data_addr, (int'(b) + k) % 16);
        chk("wgt_addr", wgt_addr, k);
        k++;
      end
      if (result_valid) begin
        done = 1;
      end else if (cnt >= 30) begin
        chk("valid_timeout", 0, 1);
        done = 1;
      end else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    chk("taps_issued", k, K);
    chk("latency", cnt, K + 1);
  endtask

  task automatic handshake(input int hold, input bit poke);
    logic signed [15:0] r0;
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_valid", result_valid, 1);
      chk("hold_result", int'(result), int'(r0));
      chk("hold_busy", busy, 1);
      chk("hold_rd_en", rd_en, 0);
    end
    result_ready = 1'b1;
    start = poke;
    @(posedge clk); #1;
    result_ready = 1'b0;
    start = 1'b0;
    chk("done_valid", result_valid, 0);
    chk("done_busy", busy, 0);
    chk("kept_result", int'(result), int'(r0));
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", rd_en, 0);
        chk("idle_valid", result_valid, 0);
      end
    end
  endtask

  task automatic window(input logic [3:0] b, input int bs,
                        input int hold, input bit poke);
    launch(b, bs, 1'b1);
    collect(b);
    handshake(hold, poke);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'(i * 3 + 20);
      rom[i] = 8'(i + 1);
    end
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    rom[0] = 4; rom[1] = 5; rom[2] = 6;
  endtask

  initial begin
    load_basic();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    launch(4'd0, 10, 1'b1);
    collect(4'd0);
    chk("basic_42", int'(result), 42);
    handshake(0, 1'b0);

    for (int i = 0; i < K; i++) begin
      mem[i] = 127;
      rom[i] = 127;
    end
    window(4'd0, 32767, 1, 1'b0);

    for (int i = 0; i < K; i++) begin
      mem[i] = -100;
      rom[i] = 100;
    end
    window(4'd0, -10000, 2, 1'b0);

    for (int i = 0; i < K; i++) mem[i] = 0;
    window(4'd0, -5, 0, 1'b0);

    load_basic();
    mem[14] = 7; mem[15] = -3; mem[0] = 9;
    window(4'd14, 1, 0, 1'b0);

    load_basic();
    window(4'd0, 10, 5, 1'b1);

    launch(4'd0, 10, 1'b0);
    @(posedge clk); #1;
    chk("abort_at_tap1", wgt_addr, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_zero("abort");
    launch(4'd0, 10, 1'b1);
    collect(4'd0);
    chk("post_abort_42", int'(result), 42);
    handshake(0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] = 8'($urandom);
        rom[i] = 8'($urandom);
      end
      window(4'($urandom), int'($signed(16'($urandom))),
             int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
